z_serial_sub: RTL

Z_SERIAL_SUB -- requirements
Module: z_serial_sub

---
 rtl/z_serial_sub_if.sv | 24 ++
 rtl/z_serial_sub.sv | 102 ++++++++++
 2 files changed

// File: rtl/z_serial_sub_if.sv
// Operand/result handshake bundle for z_serial_sub.
// master = producer/consumer side, slave = the serial subtractor.
interface z_serial_sub_if #(parameter int n = 8);
   logic         in_valid;
   logic         in_ready;
   logic [n-1:0] a;
   logic [n-1:0] b;
   logic         b_in;
   logic         out_valid;
   logic         out_ready;
   logic [n-1:0] diff;
   logic         b_out;
   logic         ovf;

   modport master (
      output in_valid, a, b, b_in, out_ready,
      input  in_ready, out_valid, diff, b_out, ovf
   );

   modport slave (
      input  in_valid, a, b, b_in, out_ready,
      output in_ready, out_valid, diff, b_out, ovf
   );
endinterface

// File: rtl/z_serial_sub.sv
// Digit-serial subtractor: k bits of a - b - b_in per clock, LSB digit first.
// Define Z_SERIAL_SUB_OVF_EN to build the two's-complement overflow flag.
module z_serial_sub #(
   parameter int n = 8,
   parameter int k = 2,
   parameter int D = 2
) (
   input logic          clk,
   input logic          rst,
   z_serial_sub_if.slave bus
);
   localparam int DIGITS = n / k;
   localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

   // D models gate delay in simulation only; it must not alter cycle behaviour.
   if (n < k || (n % k) != 0 || D < 0) begin : g_bad_cfg
      $error("z_serial_sub: n must be a positive multiple of k, D >= 0");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [n-1:0]  a_r, b_r, diff_r;
   logic          borrow, b_out_r, in_ready_r, out_valid_r;
   logic [k-1:0]  a_dig, b_dig, dig;
   logic          dig_bor;

   always_comb begin
      a_dig = a_r[cnt*k +: k];
      b_dig = b_r[cnt*k +: k];
      {dig_bor, dig} = {1'b0, a_dig} - {1'b0, b_dig} - {{k{1'b0}}, borrow};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         a_r         <= '0;
         b_r         <= '0;
         diff_r      <= '0;
         borrow      <= 1'b0;
         b_out_r     <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               a_r        <= bus.a;
               b_r        <= bus.b;
               borrow     <= bus.b_in;
               cnt        <= '0;
               in_ready_r <= 1'b0;
               state      <= RUN;
            end
            RUN: begin
               diff_r[cnt*k +: k] <= dig;
               borrow             <= dig_bor;
               if (cnt == LAST) begin
                  b_out_r     <= dig_bor;
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: if (bus.out_ready) begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               state       <= IDLE;
            end
            default: begin
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.diff      = diff_r;
   assign bus.b_out     = b_out_r;

`ifdef Z_SERIAL_SUB_OVF_EN
   logic ovf_r;

   // The final digit carries the result sign bit, so overflow resolves on the last RUN edge.
   always_ff @(posedge clk) begin
      if (rst)
         ovf_r <= 1'b0;
      else if (state == RUN && cnt == LAST)
         ovf_r <= (a_r[n-1] != b_r[n-1]) && (dig[k-1] != a_r[n-1]);
   end

   assign bus.ovf = ovf_r;
`else
   assign bus.ovf = 1'b0;
`endif
endmodule
